// File: rtl/strip_mem_arbiter_if.sv
// strip_mem_arbiter_if
// Bundles the strip-driver request side and the frame-buffer RAM side of the
// strip memory arbiter.
//
// Handshake: a strip holds req[i] high with its local index on addr[i]. The
// arbiter answers with a single-cycle rdy[i] pulse, and data is valid in that
// same cycle. There is no backpressure on rdy. The driver clears req[i] on the
// edge after it sees rdy[i]. On the RAM side, ram_en is a one-cycle read strobe
// with ram_addr. ram_data is valid exactly RAM_LATENCY cycles later.
//
// Signals:
//   req      strip -> arbiter  per-strip read request
//   addr     strip -> arbiter  packed local addresses, strip i at [i*AW +: AW]
//   rdy      arbiter -> strip  per-strip one-cycle ready pulse
//   data     arbiter -> strip  shared read byte
//   ram_en   arbiter -> RAM    read strobe
//   ram_addr arbiter -> RAM    physical read address
//   ram_data RAM -> arbiter    read byte
//
// Modports: slave is the arbiter's view; master is the environment's view
// (strips plus RAM).
interface strip_mem_arbiter_if #(
    parameter int NUM_STRIPS    = 4,
    parameter int ADDRESS_WIDTH = 13
);
    logic [NUM_STRIPS-1:0]               req;
    logic [NUM_STRIPS*ADDRESS_WIDTH-1:0] addr;
    logic [NUM_STRIPS-1:0]               rdy;
    logic [7:0]                          data;
    logic                                ram_en;
    logic [ADDRESS_WIDTH-1:0]            ram_addr;
    logic [7:0]                          ram_data;

    modport slave (
        input  req, addr, ram_data,
        output rdy, data, ram_en, ram_addr
    );

    modport master (
        output req, addr, ram_data,
        input  rdy, data, ram_en, ram_addr
    );
endinterface

// File: rtl/strip_mem_arbiter.sv
// strip_mem_arbiter
// Round-robin arbiter that shares one synchronous frame-buffer read port among
// NUM_STRIPS LED strip drivers. Each grant translates the strip's local index
// to BASE_ADDRESS + strip*STRIP_STRIDE + index (mod 2^ADDRESS_WIDTH). It then
// issues one RAM read and returns the byte with a one-cycle rdy pulse. Only one
// transaction is ever outstanding.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        strip_mem_arbiter_if.slave (req/addr/rdy/data, ram_*)
//   busy       high whenever the FSM is not in IDLE
//   grant_idx  strip being served or last served
//   state_dbg  current FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Timing: for a request sampled in IDLE at cycle T, ram_en is high in T+1.
// rdy and data are valid in T+2+RAM_LATENCY, and the FSM is back in IDLE at
// T+3+RAM_LATENCY. All outputs are registered.
module strip_mem_arbiter #(
    parameter int NUM_STRIPS    = 4,
    parameter int ADDRESS_WIDTH = 13,
    parameter int STRIP_STRIDE  = 9,
    parameter int BASE_ADDRESS  = 0,
    parameter int RAM_LATENCY   = 1,
    localparam int GW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    strip_mem_arbiter_if.slave     bus,
    output logic                   busy,
    output logic [GW-1:0]          grant_idx,
    output logic [1:0]             state_dbg
);
    // The wait counter only has to hold RAM_LATENCY-1.
    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [GW-1:0]            last;
    logic [CW-1:0]            cnt;
    logic [GW-1:0]            win_idx;
    logic [ADDRESS_WIDTH-1:0] win_addr;
    logic [ADDRESS_WIDTH-1:0] phys;

    logic                     ram_en_q;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q;
    logic [7:0]               data_q;
    logic [NUM_STRIPS-1:0]    rdy_q;
    logic                     busy_q;
    logic [GW-1:0]            grant_q;

    // Round-robin pick. Distance is measured from last+1, wrapping mod
    // NUM_STRIPS. The requesting strip with the smallest distance wins, so the
    // most recently served strip has the lowest priority.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_STRIPS-1:0] r,
                                              input logic [GW-1:0] l);
        logic [GW-1:0] pick;
        int            best_d;
        int            d;
        pick   = l;
        best_d = NUM_STRIPS;
        for (int j = 0; j < NUM_STRIPS; j++) begin
            d = j - int'(l) - 1;
            if (d < 0) d = d + NUM_STRIPS;
            if (r[j] && d < best_d) begin
                best_d = d;
                pick   = GW'(j);
            end
        end
        return pick;
    endfunction

    // Winner selection and address translation. Only meaningful in IDLE.
    always_comb begin
        win_idx  = rr_pick(bus.req, last);
        win_addr = '0;
        for (int j = 0; j < NUM_STRIPS; j++) begin
            if (GW'(j) == win_idx) win_addr = bus.addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
        // Truncating each term to ADDRESS_WIDTH gives the required wrap.
        phys = ADDRESS_WIDTH'(BASE_ADDRESS)
             + ADDRESS_WIDTH'(int'(win_idx) * STRIP_STRIDE)
             + win_addr;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|bus.req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and all outputs are registered from the current state, so each
    // output changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= GW'(NUM_STRIPS - 1);
            cnt        <= '0;
            grant_q    <= '0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            data_q     <= '0;
            rdy_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state    <= state_next;
            busy_q   <= (state_next != IDLE);
            ram_en_q <= 1'b0;
            rdy_q    <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q    <= win_idx;
                        ram_addr_q <= phys;
                        ram_en_q   <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt <= CW'(RAM_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // ram_data is valid only in this cycle.
                        data_q <= bus.ram_data;
                        rdy_q  <= NUM_STRIPS'(1) << grant_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    last <= grant_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_en   = ram_en_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.data     = data_q;
    assign bus.rdy      = rdy_q;
    assign busy         = busy_q;
    assign grant_idx    = grant_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_strip_mem_arbiter.sv
// tb_strip_mem_arbiter
// Directed bench for strip_mem_arbiter. dut_a uses default parameters.
// dut_b uses BASE_ADDRESS=8190 and RAM_LATENCY=3. Each DUT has a small RAM
// model that returns ram_word(addr) exactly RAM_LATENCY cycles after ram_en and
// 8'hEE otherwise, so sampling in the wrong cycle shows up in data.
module tb_strip_mem_arbiter;
    logic clk;
    logic rst;

    strip_mem_arbiter_if #(.NUM_STRIPS(4), .ADDRESS_WIDTH(13)) a_if ();
    strip_mem_arbiter_if #(.NUM_STRIPS(4), .ADDRESS_WIDTH(13)) b_if ();

    logic       a_busy, b_busy;
    logic [1:0] a_gnt, b_gnt;
    logic [1:0] a_st, b_st;

    strip_mem_arbiter dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (a_if.slave),
        .busy      (a_busy),
        .grant_idx (a_gnt),
        .state_dbg (a_st)
    );

    strip_mem_arbiter #(.BASE_ADDRESS(8190), .RAM_LATENCY(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (b_if.slave),
        .busy      (b_busy),
        .grant_idx (b_gnt),
        .state_dbg (b_st)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models
    function automatic logic [7:0] ram_word(input logic [12:0] a);
        return a[7:0] ^ 8'hA5 ^ {3'b000, a[12:8]};
    endfunction

    logic        a_v;
    logic [12:0] a_a;
    always @(posedge clk) begin
        a_v <= a_if.ram_en;
        a_a <= a_if.ram_addr;
    end
    assign a_if.ram_data = a_v ? ram_word(a_a) : 8'hEE;

    logic [2:0]  b_v;
    logic [12:0] b_a0, b_a1, b_a2;
    always @(posedge clk) begin
        b_v  <= {b_v[1:0], b_if.ram_en};
        b_a0 <= b_if.ram_addr;
        b_a1 <= b_a0;
        b_a2 <= b_a1;
    end
    assign b_if.ram_data = b_v[2] ? ram_word(b_a2) : 8'hEE;

    // Scoreboard
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        a_if.req = '0;
        b_if.req = '0;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) at negedges for any rdy bit of the selected DUT.
    // n counts the negedges that had no rdy before the pulse.
    task automatic wait_rdy(input int sel, input int budget,
                            output logic [3:0] r, output logic [7:0] d, output int n);
        n = 0;
        r = '0;
        d = '0;
        while (n < budget) begin
            @(negedge clk);
            if (sel == 0 && a_if.rdy != '0) begin r = a_if.rdy; d = a_if.data; break; end
            if (sel == 1 && b_if.rdy != '0) begin r = b_if.rdy; d = b_if.data; break; end
            n++;
        end
    endtask

    // Holds mask on dut_a and expects grants in exp_q order. Each strip drops
    // its bit on the edge after its rdy pulse.
    task automatic run_queue(input string tag, input logic [3:0] mask);
        logic [3:0]  r;
        logic [7:0]  d;
        logic [12:0] la;
        int          n;
        int          k;
        a_if.req = mask;
        while (exp_q.size() > 0) begin
            k = int'(exp_q.pop_front());
            la = a_if.addr[k*13 +: 13];
            wait_rdy(0, 12, r, d, n);
            check({tag, "_rdy"}, 32'(r), 32'(1) << k);
            check({tag, "_gnt"}, 32'(a_gnt), 32'(k));
            check({tag, "_data"}, 32'(d), 32'(ram_word(13'(k * 9) + la)));
            check({tag, "_gap"}, 32'(n), 32'd3);
            tick();
            a_if.req = a_if.req & ~r;
        end
    endtask

    logic [3:0] r;
    logic [7:0] d;
    int         n;

    initial begin
        rst = 1'b1;
        a_if.req = '0;
        a_if.addr = '0;
        b_if.req = '0;
        b_if.addr = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_rdy", 32'(a_if.rdy), 0);
        check("rst_ram_en", 32'(a_if.ram_en), 0);
        check("rst_ram_addr", 32'(a_if.ram_addr), 0);
        check("rst_data", 32'(a_if.data), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_gnt", 32'(a_gnt), 0);

        // Single request: strip 0, local index 5
        tick();
        a_if.addr = {13'd0, 13'd0, 13'd0, 13'd5};
        a_if.req  = 4'b0001;
        @(negedge clk);
        check("single_busy_t0", 32'(a_busy), 0);
        tick();
        @(negedge clk);
        check("single_ram_en", 32'(a_if.ram_en), 1);
        check("single_ram_addr", 32'(a_if.ram_addr), 5);
        check("single_busy_t1", 32'(a_busy), 1);
        tick();
        @(negedge clk);
        check("single_ram_en_off", 32'(a_if.ram_en), 0);
        check("single_rdy_early", 32'(a_if.rdy), 0);
        tick();
        @(negedge clk);
        check("single_rdy", 32'(a_if.rdy), 32'h1);
        check("single_data", 32'(a_if.data), 32'(8'hA0));
        tick();
        a_if.req = '0;
        @(negedge clk);
        check("single_rdy_off", 32'(a_if.rdy), 0);
        check("single_busy_t4", 32'(a_busy), 0);

        // Address offset: strip 2, index 7 -> 2*9+7 = 25
        do_reset();
        a_if.addr = {13'd0, 13'd7, 13'd0, 13'd0};
        a_if.req  = 4'b0100;
        tick();
        @(negedge clk);
        check("offs_ram_addr", 32'(a_if.ram_addr), 25);
        wait_rdy(0, 10, r, d, n);
        check("offs_rdy", 32'(r), 32'h4);
        check("offs_data", 32'(d), 32'(ram_word(13'd25)));
        tick();
        a_if.req = '0;

        // Wrap: dut_b base 8190, strip 0 index 3 -> 8193 mod 8192 = 1
        do_reset();
        b_if.addr = {13'd0, 13'd0, 13'd0, 13'd3};
        b_if.req  = 4'b0001;
        tick();
        @(negedge clk);
        check("wrap_ram_en", 32'(b_if.ram_en), 1);
        check("wrap_ram_addr", 32'(b_if.ram_addr), 1);
        wait_rdy(1, 10, r, d, n);
        check("wrap_rdy", 32'(r), 32'h1);
        check("wrap_lat", 32'(n), 3);
        check("wrap_data", 32'(d), 32'(ram_word(13'd1)));
        tick();
        b_if.req = '0;

        // Fairness: all four requesting
        do_reset();
        a_if.addr = {13'd4, 13'd3, 13'd2, 13'd1};
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        run_queue("fair", 4'b1111);
        @(negedge clk);
        check("fair_idle", 32'(a_busy), 0);

        // Rotation: after strip 2, 0101 -> 0 then 2; after strip 0, 0101 -> 2 then 0
        do_reset();
        a_if.addr = {13'd10, 13'd11, 13'd12, 13'd13};
        exp_q = '{2'd2};
        run_queue("rot_a", 4'b0100);
        exp_q = '{2'd0, 2'd2};
        run_queue("rot_b", 4'b0101);
        exp_q = '{2'd0};
        run_queue("rot_c", 4'b0001);
        exp_q = '{2'd2, 2'd0};
        run_queue("rot_d", 4'b0101);

        // Reset mid-WAIT on dut_b (latency 3): phys = 8190+2 = 8192 -> 0
        do_reset();
        b_if.addr = {13'd0, 13'd0, 13'd0, 13'd2};
        b_if.req  = 4'b0001;
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(b_busy), 1);
        check("mid_rdy", 32'(b_if.rdy), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy", 32'(b_if.rdy), 0);
        check("mid_rst_ram_en", 32'(b_if.ram_en), 0);
        check("mid_rst_ram_addr", 32'(b_if.ram_addr), 0);
        check("mid_rst_data", 32'(b_if.data), 0);
        check("mid_rst_busy", 32'(b_busy), 0);
        check("mid_rst_gnt", 32'(b_gnt), 0);
        wait_rdy(1, 12, r, d, n);
        check("mid_reserve_rdy", 32'(r), 32'h1);
        check("mid_reserve_lat", 32'(n), 4);
        check("mid_reserve_data", 32'(d), 32'(ram_word(13'd0)));
        tick();
        b_if.req = '0;

        // Early drop on dut_b: strip 1 index 4 -> 8190+9+4 = 8203 mod 8192 = 11
        do_reset();
        b_if.addr = {13'd0, 13'd0, 13'd4, 13'd0};
        b_if.req  = 4'b0010;
        tick();
        b_if.req = '0;
        @(negedge clk);
        check("drop_ram_en", 32'(b_if.ram_en), 1);
        check("drop_ram_addr", 32'(b_if.ram_addr), 11);
        check("drop_gnt", 32'(b_gnt), 1);
        wait_rdy(1, 10, r, d, n);
        check("drop_rdy", 32'(r), 32'h2);
        check("drop_lat", 32'(n), 3);
        check("drop_data", 32'(d), 32'(ram_word(13'd11)));
        tick();
        @(negedge clk);
        check("drop_rdy_off", 32'(b_if.rdy), 0);
        check("drop_busy_off", 32'(b_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
